// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the BCD scan display
// Holds the digit-state enum, the active-low glyph table {g,f,e,d,c,b,a}
// (nibbles 10-15 render as a dash), the blank/off constants and the
// anode pattern lookup.
package seg7_pkg;

    typedef enum logic [1:0] {
        UNITS    = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } digit_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] AN_OFF    = 3'b111;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    function automatic logic [2:0] an_pattern(input digit_e d);
        case (d)
            UNITS:    an_pattern = 3'b110;
            TENS:     an_pattern = 3'b101;
            HUNDREDS: an_pattern = 3'b011;
            default:  an_pattern = AN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - word input and display output bundle
// bcd   : packed BCD word [11:8] hundreds, [7:4] tens, [3:0] units
// load  : one-cycle capture strobe for bcd
// seg   : active-low segments {g,f,e,d,c,b,a}
// an    : active-low one-hot digit anodes, an[0] = units
// frame : one-cycle pulse when a new display word is adopted
interface bcd_scan_display_if;
    logic [11:0] bcd;
    logic        load;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame;

    modport master (output bcd, output load, input seg, input an, input frame);
    modport slave  (input bcd, input load, output seg, output an, output frame);
endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational nibble to active-low seven-segment decoder
// nibble_i : 4-bit digit value (10-15 decode to a dash)
// seg_o    : active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - time-multiplexed 3-digit common-anode display driver
// clk : single clock, rising edge
// rst : asynchronous active-high reset
// bus : bcd_scan_display_if.slave (bcd/load in, seg/an/frame out)
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_display_if.slave  bus
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    digit_e           state_q, state_d;
    logic [11:0]      disp_q, disp_d;
    logic [11:0]      pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             frame_q, frame_d;

    logic             tc;
    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             blank;

    assign tc   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign wrap = tc && (state_q == HUNDREDS);

    // Digit FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNITS;
        end else begin
            state_q <= state_d;
        end
    end

    // Digit FSM: next state, advancing only at prescaler terminal count
    always_comb begin
        state_d = state_q;
        if (tc) begin
            case (state_q)
                UNITS:    state_d = TENS;
                TENS:     state_d = HUNDREDS;
                HUNDREDS: state_d = UNITS;
                default:  state_d = UNITS;
            endcase
        end
    end

    // Prescaler and word path. A load landing on the wrap cycle bypasses the
    // shadow register so the best-case load-to-display latency is one cycle.
    always_comb begin
        div_cnt_d = tc ? '0 : div_cnt_q + DIV_W'(1);
        disp_d    = disp_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        frame_d   = 1'b0;
        if (wrap && bus.load) begin
            disp_d   = bus.bcd;
            pend_v_d = 1'b0;
            frame_d  = 1'b1;
        end else if (wrap && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
            frame_d  = 1'b1;
        end else if (bus.load) begin
            pend_d   = bus.bcd;
            pend_v_d = 1'b1;
        end
    end

    // Digit mux feeding the single decoder
    always_comb begin
        case (state_q)
            UNITS:    nibble = disp_q[3:0];
            TENS:     nibble = disp_q[7:4];
            HUNDREDS: nibble = disp_q[11:8];
            default:  nibble = disp_q[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Units is never blanked so a zero value still shows a single "0".
    always_comb begin
        case (state_q)
            TENS:     blank = (disp_q[11:4] == 8'h00);
            HUNDREDS: blank = (disp_q[11:8] == 4'h0);
            default:  blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Digit FSM: outputs. The first cycle of every digit keeps the anodes off
    // while the segments already carry the new glyph, avoiding ghosting.
    always_comb begin
        seg_d = blank ? SEG_BLANK : glyph;
        an_d  = (div_cnt_q == '0) ? AN_OFF : an_pattern(state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

    localparam int D = 4;
    localparam int F = 3 * D;

    logic clk = 1'b0;
    logic rst;

    bcd_scan_display_if bus ();

    bcd_scan_display #(.CLK_DIV(D), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    logic [11:0] m_disp, m_pend;
    logic        m_pend_v;
    logic [6:0]  e_seg;
    logic [2:0]  e_an;
    logic        e_frame;

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] shown(input logic [11:0] w, input int d);
        logic [3:0] nib;
        nib = 4'(w >> (4 * d));
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 2 && w[11:8] == 4'h0) return 7'h7F;
        if (d == 1 && w[11:4] == 8'h00) return 7'h7F;
`endif
        return glyph_of(nib);
    endfunction

    task automatic model_reset;
        n        = 0;
        m_disp   = 12'h000;
        m_pend   = 12'h000;
        m_pend_v = 1'b0;
    endtask

    // One clock: cycle k = n is the cycle ending at the coming edge; the
    // outputs after that edge show digit (k/D)%3 of the word held during k.
    task automatic step(input logic ld, input logic [11:0] b);
        int k;
        int d;
        k       = n;
        d       = (k / D) % 3;
        e_an    = (k % D == 0) ? 3'b111 : ~(3'b001 << d);
        e_seg   = shown(m_disp, d);
        e_frame = 1'b0;
        if (k % F == F - 1) begin
            if (ld) begin
                m_disp = b; m_pend_v = 1'b0; e_frame = 1'b1;
            end else if (m_pend_v) begin
                m_disp = m_pend; m_pend_v = 1'b0; e_frame = 1'b1;
            end
        end else if (ld) begin
            m_pend = b; m_pend_v = 1'b1;
        end
        bus.load = ld;
        bus.bcd  = b;
        @(posedge clk);
        n++;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.load = 1'b0; bus.bcd = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({bus.seg, bus.an, bus.frame} !== {7'h7F, 3'b111, 1'b0}) begin
            n_bad++; $display("FAIL reset_state got %h/%b/%b want 7f/111/0", bus.seg, bus.an, bus.frame);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 12'h000);
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL reset_scan n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
            if (n == 2) begin
                n_cmp++;
                if ({bus.seg, bus.an} !== {7'b1000000, 3'b110}) begin
                    n_bad++; $display("FAIL reset_first_lit got %b/%b want 1000000/110", bus.seg, bus.an);
                end
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.seg, bus.an, bus.frame} !== {7'h7F, 3'b111, 1'b0}) begin
            n_bad++; $display("FAIL reset_async got %h/%b/%b want 7f/111/0", bus.seg, bus.an, bus.frame);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_scan_order;
        int seen;
        seen = 0;
        step(1'b1, 12'h042);
        for (int i = 0; i < F + 2 && seen == 0; i++) begin
            step(1'b0, 12'h000);
            if (bus.frame === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen != 1) begin
            n_bad++; $display("FAIL scan_frame got none want pulse within %0d cycles", F + 2);
        end
        for (int i = 0; i < F; i++) begin
            step(1'b0, 12'h000);
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL scan_order n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
        end
    endtask

    task automatic test_tear_free;
        int frames;
        frames = 0;
        while (n % F != 0) step(1'b0, 12'h000);
        step(1'b1, 12'h099);
        for (int i = 0; i < F + 4; i++) begin
            step((i == F + 1), 12'h255);
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL tear_free n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
        end
        for (int i = 0; i < F; i++) begin
            step(1'b0, 12'h000);
            if (bus.frame === 1'b1) frames++;
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL tear_free2 n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
        end
        n_cmp++;
        if (frames != 1) begin
            n_bad++; $display("FAIL tear_frames got %0d want 1", frames);
        end
    endtask

    task automatic test_coincident;
        int frames;
        frames = 0;
        while (n % F != F - 1) step(1'b0, 12'h000);
        step(1'b1, 12'h127);
        n_cmp++;
        if (bus.frame !== 1'b1) begin
            n_bad++; $display("FAIL coincident_frame got %b want 1", bus.frame);
        end
        for (int i = 0; i < F; i++) begin
            step(1'b0, 12'h000);
            if (bus.frame === 1'b1) frames++;
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL coincident n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
        end
        n_cmp++;
        if (frames != 0) begin
            n_bad++; $display("FAIL coincident_pend got %0d frames want 0", frames);
        end
    endtask

    task automatic test_invalid;
        step(1'b1, 12'h0A3);
        while (n % F != 0) step(1'b0, 12'h000);
        for (int i = 0; i < F; i++) begin
            step(1'b0, 12'h000);
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL invalid n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
            if (bus.an === 3'b101) begin
                n_cmp++;
                if (bus.seg !== 7'b0111111) begin
                    n_bad++; $display("FAIL invalid_dash got %b want 0111111", bus.seg);
                end
            end
        end
    endtask

    task automatic test_blank;
        logic [6:0] want_hi;
`ifdef LEADING_ZERO_BLANK_EN
        want_hi = 7'b1111111;
`else
        want_hi = 7'b1000000;
`endif
        step(1'b1, 12'h009);
        while (n % F != 0) step(1'b0, 12'h000);
        for (int i = 0; i < F; i++) begin
            step(1'b0, 12'h000);
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL blank n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
            if (bus.an === 3'b011 || bus.an === 3'b101) begin
                n_cmp++;
                if (bus.seg !== want_hi) begin
                    n_bad++; $display("FAIL blank_lead an=%b got %b want %b", bus.an, bus.seg, want_hi);
                end
            end else if (bus.an === 3'b110) begin
                n_cmp++;
                if (bus.seg !== 7'b0010000) begin
                    n_bad++; $display("FAIL blank_units got %b want 0010000", bus.seg);
                end
            end
        end
    endtask

    task automatic test_random;
        logic        ld;
        logic [11:0] b;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 5) == 0);
            b  = 12'($urandom);
            step(ld, b);
            n_cmp++;
            if ({bus.seg, bus.an, bus.frame} !== {e_seg, e_an, e_frame}) begin
                n_bad++; $display("FAIL random n=%0d got %h/%b/%b want %h/%b/%b", n, bus.seg, bus.an, bus.frame, e_seg, e_an, e_frame);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.load = 1'b0;
        bus.bcd  = 12'h000;
        model_reset();
        test_reset();
        test_scan_order();
        test_tear_free();
        test_coincident();
        test_invalid();
        test_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
